// File: rtl/i2s_dac_tx.sv
// Mono sample FIFO feeding a Philips-I2S serialiser for the WM8731 DAC.
// Both slots of a frame carry the same held sample.
module i2s_dac_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_HALF  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  status_clr,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  bclk,
  output logic                  dac_lr_clk,
  output logic                  dac_dat
);

  localparam int DW   = DATA_WIDTH;
  localparam int BW   = $clog2(2 * SLOT_BITS);
  localparam int DIVW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_HALF - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0]   SLOT     = BW'(SLOT_BITS);
  localparam logic [BW-1:0]   DW_K     = BW'(DATA_WIDTH);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  logic [DIVW-1:0] div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_nxt;
  logic [BW-1:0]   k_nxt;
  logic            lr_nxt;
  logic            dat_nxt;
  logic [DW-1:0]   held;
  logic [DW-1:0]   shifted;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            div_wrap;
  logic            fall_evt;
  logic            frame_start;
  logic            push;
  logic            pop;

  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    fall_evt    = bclk && div_wrap;
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    lr_nxt      = (bit_nxt >= SLOT);
    k_nxt       = lr_nxt ? bit_nxt - SLOT : bit_nxt;
    // MSB lands one BCLK after the LRCK edge (k=1)
    shifted     = held << (k_nxt - 1'b1);
    dat_nxt     = (k_nxt != '0) && (k_nxt <= DW_K) && shifted[DW-1];
    frame_start = fall_evt && (bit_nxt == '0);
    push        = in_valid && in_ready;
    pop         = frame_start && (count != '0);
    count_nxt   = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + 1'b1;
      pop && !push: count_nxt = count - 1'b1;
      default:      count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= BIT_LAST;
      dac_lr_clk <= 1'b1;
      dac_dat    <= 1'b0;
      held       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready   <= 1'b1;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) bclk <= !bclk;
      if (fall_evt) begin
        bit_cnt    <= bit_nxt;
        dac_lr_clk <= lr_nxt;
        dac_dat    <= dat_nxt;
      end
      if (pop) begin
        held   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count    <= count_nxt;
      in_ready <= (count_nxt < DEPTH_C);
      // a set event in the same cycle beats status_clr
      underrun <= (frame_start && (count == '0)) ||
                  (underrun && !status_clr);
      overrun  <= (in_valid && !in_ready) ||
                  (overrun && !status_clr);
    end
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Audio output stage directly downstream of the FM demodulator.
- Accepts signed mono samples through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each sample as a Philips-I2S stereo frame (same sample on left and right) toward the WM8731 DAC, generating BCLK, DACLRCK and DACDAT.
- Runs entirely in the codec master-clock domain; the upstream stage delivers samples already synchronised to clk.

Parameters:
- DATA_WIDTH, 16, sample width in bits (two's complement).
- SLOT_BITS, 32, BCLK periods per channel slot; must be ≥ DATA_WIDTH+1.
- BCLK_HALF, 4, clk cycles per BCLK half-period (BCLK = clk/(2*BCLK_HALF)).
- FIFO_DEPTH, 4, sample buffer depth; power of two, ≥2.

Ports:
- clk, input, 1, codec master clock (24 MHz).
- reset_n, input, 1, asynchronous active-low reset.
- in_dat, input, DATA_WIDTH, audio sample.
- in_valid, input, 1, in_dat valid this cycle.
- in_ready, output, 1, FIFO not full.
- status_clr, input, 1, synchronous clear of the sticky flags.
- underrun, output, 1, sticky: frame started with the FIFO empty.
- overrun, output, 1, sticky: sample offered while in_ready=0.
- bclk, output, 1, I2S bit clock.
- dac_lr_clk, output, 1, I2S word select (0 = left, 1 = right).
- dac_dat, output, 1, I2S serial data.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream) forces:
  - bclk=0, dac_lr_clk=1, dac_dat=0
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1
  - FIFO empty, held sample=0, underrun=0, overrun=0
  - in_ready=1 one cycle after deassertion.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1; bclk toggles in the cycle div_cnt wraps.
  - First rising edge of bclk occurs BCLK_HALF cycles after reset release.
- Falling-edge event: the clk cycle in which bclk goes 1→0. All serial outputs update only on falling-edge events; the codec samples on rising edges.
- On each falling-edge event:
  - bit_cnt increments, wrapping 2*SLOT_BITS-1 → 0.
  - dac_lr_clk = (new bit_cnt ≥ SLOT_BITS).
  - Let k = new bit_cnt mod SLOT_BITS. dac_dat = bit (DATA_WIDTH-k) of the held sample for 1≤k≤DATA_WIDTH (MSB at k=1, i.e. one BCLK after the LRCK edge), else 0.
- Frame start is the falling-edge event where bit_cnt becomes 0:
  - FIFO non-empty: pop the head into the held sample in that same cycle. dac_dat for k=0 is 0, so the new sample is used from k=1.
  - FIFO empty: keep the held sample (repeat) and set underrun.
- The left and right slots carry the same held sample.
- FIFO:
  - Write when in_valid && in_ready.
  - in_ready = count < FIFO_DEPTH, registered from the count.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, but in_ready was already 0, so the push is refused and overrun is set.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged.
  - Push into an empty FIFO in the frame-start cycle: no pop. The sample is held until the next frame; underrun is set.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Overrun: in_valid && !in_ready drops the sample and sets overrun.
- Flag priority: status_clr clears both flags, but a set event in the same cycle wins (the flag stays 1).
- Default rates: BCLK = 3 MHz, frame = 64 BCLK, fs = 46.875 kHz. A 32 kHz source therefore causes periodic repeat frames and underrun is expected; underrun is diagnostic only.

Test Plan:
- Reset held, then released with no input → bclk period 8 clk, dac_lr_clk period 512 clk, dac_dat constant 0, underrun=1 after the first frame start (clk 8 after release).
- Push 16'hA5C3 then idle → next frame: left and right slots each shift 1010_0101_1100_0011 MSB-first on bclk periods k=1..16, zeros for k=17..31 and k=0; dac_lr_clk low for the left slot, high for the right.
- Push 16'h8001 then 16'h7FFE within one frame → consecutive frames carry 8001 then 7FFE; the following frame repeats 7FFE; underrun sets on that third frame.
- Hold in_valid=1 continuously from reset with values 1,2,3,… → in_ready drops after 4 accepted samples; overrun=1; frames emit 1,2,3,4,… in order with refused values lost.
- Assert status_clr alone with underrun=1 → underrun=0 next cycle. Assert status_clr coincident with a frame start on an empty FIFO → underrun stays 1.
- Assert reset_n low mid-slot (bit_cnt=20) → all outputs go to reset values immediately without waiting for a clock; FIFO contents are discarded; after release, the first frame starts 8 clk later.
